// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, stall bit indices and the EX/MEM register layout
// for the memory-access stage.
package mem_stage_pkg;

    localparam int EX_INST_INFO = 195;
    localparam int MEM_TO_WB_WD = 180;
    localparam int MEM_TO_RF_WD = 104;
    localparam int HILO_WD      = 66;
    localparam int EXCEPT_WD    = 44;

    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    localparam logic [31:0] ZeroWord = 32'h0;

    // EX/MEM register, MSB first; matches the ex_to_mem_bus packing.
    typedef struct packed {
        logic [EXCEPT_WD-1:0] exceptinfo;
        logic [7:0]           mem_op;     // {lb, lbu, lh, lhu, lw, sb, sh, sw}
        logic [HILO_WD-1:0]   hilo_bus;
        logic [31:0]          pc;
        logic                 ram_en;
        logic                 ram_wen;
        logic [3:0]           ram_sel;
        logic                 sel_rf_res;
        logic                 rf_we;
        logic [4:0]           rf_waddr;
        logic [31:0]          ex_result;
    } ex_mem_t;

    function automatic logic is_load(input ex_mem_t inst);
        return (|inst.mem_op[7:3]) & inst.ram_en;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: selects and extends the loaded byte/halfword from a 32-bit SRAM word.
// Ports:
//   mem_op  in  5   {lb, lbu, lh, lhu, lw}
//   addr    in  2   low address bits of the access
//   rdata   in  32  raw SRAM word
//   data    out 32  aligned, extended load result
module load_align (
    input  logic [4:0]  mem_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        unused_lw;

    // lw and the no-load case both pass the whole word through.
    assign unused_lw = mem_op[0];

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        if (mem_op[4])      data = {{24{byte_sel[7]}}, byte_sel};
        else if (mem_op[3]) data = {24'b0, byte_sel};
        else if (mem_op[2]) data = {{16{half_sel[15]}}, half_sel};
        else if (mem_op[1]) data = {16'b0, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage pipeline. Owns the EX/MEM register, aligns
// load data and holds the one-cycle-valid SRAM read data across MEM stalls.
// Ports:
//   clk, rst         clock, async active-high reset
//   stall[5:0]       stall[3] = EX held, stall[4] = MEM held
//   flush            kill the instruction entering the register
//   ex_to_mem_bus    EX stage result bus
//   data_sram_rdata  SRAM read data, valid in the first MEM cycle of a load
//   mem_to_wb_bus    {exceptinfo, hilo_bus, pc, rf_we, rf_waddr, rf_wdata}
//   mem_to_rf_bus    {hilo_bus, rf_we, rf_waddr, rf_wdata} forwarding to ID
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int EX_WD  = EX_INST_INFO,
    parameter int WB_WD  = MEM_TO_WB_WD,
    parameter int FWD_WD = MEM_TO_RF_WD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [EX_WD-1:0]  ex_to_mem_bus,
    input  logic [31:0]       data_sram_rdata,
    output logic [WB_WD-1:0]  mem_to_wb_bus,
    output logic [FWD_WD-1:0] mem_to_rf_bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FRESH = 2'd1;
    localparam logic [1:0] HELD  = 2'd2;

    ex_mem_t     ex_in;
    ex_mem_t     mem_d, mem_q;
    logic [1:0]  state_d, state_q;
    logic [31:0] hold_q;
    logic [31:0] rdata_src;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;
    logic        rf_we_out;
    logic        entry_load;
    logic        reg_holds;
    logic        unused_bits;

    assign ex_in      = ex_mem_t'(ex_to_mem_bus);
    assign reg_holds  = stall[STALL_EX] & stall[STALL_MEM];
    assign entry_load = ~flush & ~stall[STALL_EX] & is_load(ex_in);

    // Pipeline register
    always_comb begin
        mem_d = mem_q;
        if (flush)                                        mem_d = '0;
        else if (stall[STALL_EX] && !stall[STALL_MEM])    mem_d = '0;
        else if (!stall[STALL_EX])                        mem_d = ex_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    // Read-data hold FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: when the register takes a new entry, a load means FRESH,
    // anything else (including a bubble) means IDLE.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!reg_holds) state_d = entry_load ? FRESH : IDLE;
                FRESH,
                HELD:    state_d = stall[STALL_MEM] ? HELD : (entry_load ? FRESH : IDLE);
                default: state_d = IDLE;
            endcase
        end
    end

    // SRAM data is only valid in the FRESH cycle; keep it for the stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= ZeroWord;
        end else if (state_q == FRESH && stall[STALL_MEM]) begin
            hold_q <= data_sram_rdata;
        end
    end

    // Output decode
    always_comb begin
        rdata_src = data_sram_rdata;
        if (state_q == HELD) rdata_src = hold_q;
    end

    load_align u_load_align (
        .mem_op (mem_q.mem_op[7:3]),
        .addr   (mem_q.ex_result[1:0]),
        .rdata  (rdata_src),
        .data   (load_data)
    );

    assign rf_wdata  = mem_q.sel_rf_res ? load_data : mem_q.ex_result;
    // A faulting instruction must never reach the register file.
    assign rf_we_out = mem_q.rf_we & (mem_q.exceptinfo[31:0] == ZeroWord);

    assign mem_to_wb_bus = {mem_q.exceptinfo, mem_q.hilo_bus, mem_q.pc,
                            rf_we_out, mem_q.rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {mem_q.hilo_bus, rf_we_out, mem_q.rf_waddr, rf_wdata};

    assign unused_bits = ^{stall[5], stall[2:0], mem_q.ram_wen, mem_q.ram_sel,
                           mem_q.mem_op[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int EX_WD  = 195;
    localparam int WB_WD  = 180;
    localparam int FWD_WD = 104;

    localparam logic [7:0]  OP_LB  = 8'h80;
    localparam logic [7:0]  OP_LBU = 8'h40;
    localparam logic [7:0]  OP_LH  = 8'h20;
    localparam logic [7:0]  OP_LHU = 8'h10;
    localparam logic [7:0]  OP_LW  = 8'h08;
    localparam logic [65:0] HILO   = 66'h2_0123_4567_89AB_CDEF;
    localparam logic [5:0]  ST_MEM = 6'b011111;

    logic              clk = 1'b0;
    logic              rst;
    logic [5:0]        stall;
    logic              flush;
    logic [EX_WD-1:0]  ex_bus;
    logic [31:0]       rdata;
    logic [WB_WD-1:0]  wb_bus;
    logic [FWD_WD-1:0] rf_bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .ex_to_mem_bus   (ex_bus),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (wb_bus),
        .mem_to_rf_bus   (rf_bus)
    );

    function automatic logic [EX_WD-1:0] mk_ex(input logic [43:0] exc, input logic [7:0] op,
                                               input logic [31:0] pc, input logic ram_en,
                                               input logic sel, input logic we,
                                               input logic [4:0] wa, input logic [31:0] res);
        return {exc, op, HILO, pc, ram_en, 1'b0, ram_en ? 4'hF : 4'h0, sel, we, wa, res};
    endfunction

    function automatic logic [WB_WD-1:0] mk_wb(input logic [43:0] exc, input logic [31:0] pc,
                                               input logic we, input logic [4:0] wa,
                                               input logic [31:0] wd);
        return {exc, HILO, pc, we, wa, wd};
    endfunction

    function automatic logic [FWD_WD-1:0] mk_rf(input logic we, input logic [4:0] wa,
                                                input logic [31:0] wd);
        return {HILO, we, wa, wd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        stall  = '0;
        flush  = 1'b0;
        rdata  = 32'hFFFF_FFFF;
        ex_bus = mk_ex(44'h0, OP_LW, 32'hBFC0_0000, 1'b1, 1'b1, 1'b1, 5'd3, 32'h40);
        tick();
        tick();
        checks++;
        if (wb_bus !== '0 || rf_bus !== '0) begin
            errors++;
            $display("FAIL reset_hold: wb=%h rf=%h, expected all zero", wb_bus, rf_bus);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (wb_bus !== '0 || rf_bus !== '0) begin
            errors++;
            $display("FAIL reset_first_cycle: wb=%h rf=%h, expected all zero", wb_bus, rf_bus);
        end
        ex_bus = '0;
        tick();
    endtask

    task automatic test_lw();
        logic [WB_WD-1:0] exp_wb;
        ex_bus = mk_ex(44'h0, OP_LW, 32'hBFC0_0100, 1'b1, 1'b1, 1'b1, 5'd5, 32'h0000_0100);
        tick();
        rdata  = 32'hDEAD_BEEF;
        ex_bus = '0;
        #1;
        exp_wb = mk_wb(44'h0, 32'hBFC0_0100, 1'b1, 5'd5, 32'hDEAD_BEEF);
        checks++;
        if (wb_bus !== exp_wb) begin
            errors++;
            $display("FAIL lw_wb: got %h expected %h", wb_bus, exp_wb);
        end
        checks++;
        if (rf_bus !== mk_rf(1'b1, 5'd5, 32'hDEAD_BEEF)) begin
            errors++;
            $display("FAIL lw_rf: got %h expected %h", rf_bus, mk_rf(1'b1, 5'd5, 32'hDEAD_BEEF));
        end
        tick();
    endtask

    // Back-to-back loads, each entering while the previous one is in MEM.
    task automatic test_align();
        logic [7:0]  ops [9] = '{OP_LB, OP_LBU, OP_LHU, OP_LH, OP_LB, OP_LB, OP_LBU, OP_LH, OP_LW};
        logic [1:0]  ads [9] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd2, 2'd0};
        logic [31:0] rds [9] = '{32'h12F4_5678, 32'h12F4_5678, 32'h12F4_5678, 32'h0000_8001,
                                 32'h0000_0080, 32'h7F00_0000, 32'h0000_AB00, 32'hABCD_0000,
                                 32'h89AB_CDEF};
        logic [31:0] exps[9] = '{32'hFFFF_FFF4, 32'h0000_00F4, 32'h0000_12F4, 32'hFFFF_8001,
                                 32'hFFFF_FF80, 32'h0000_007F, 32'h0000_00AB, 32'hFFFF_ABCD,
                                 32'h89AB_CDEF};
        ex_bus = mk_ex(44'h0, ops[0], 32'h1000, 1'b1, 1'b1, 1'b1, 5'd1, {30'h80, ads[0]});
        for (int i = 0; i < 9; i++) begin
            tick();
            rdata = rds[i];
            if (i + 1 < 9)
                ex_bus = mk_ex(44'h0, ops[i+1], 32'h1000 + 32'(4*(i+1)), 1'b1, 1'b1, 1'b1,
                               5'(i + 2), {30'h80, ads[i+1]});
            else
                ex_bus = '0;
            #1;
            checks++;
            if (rf_bus !== mk_rf(1'b1, 5'(i + 1), exps[i])) begin
                errors++;
                $display("FAIL align_%0d: got %h expected %h", i, rf_bus,
                         mk_rf(1'b1, 5'(i + 1), exps[i]));
            end
        end
        tick();
    endtask

    task automatic test_alu();
        ex_bus = mk_ex(44'h0, 8'h00, 32'h2000, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_1234);
        tick();
        rdata  = 32'hFFFF_FFFF;
        ex_bus = '0;
        #1;
        checks++;
        if (wb_bus !== mk_wb(44'h0, 32'h2000, 1'b1, 5'd7, 32'h0000_1234)) begin
            errors++;
            $display("FAIL alu_result: got %h expected %h", wb_bus,
                     mk_wb(44'h0, 32'h2000, 1'b1, 5'd7, 32'h0000_1234));
        end
        tick();
    endtask

    task automatic test_hold();
        ex_bus = mk_ex(44'h0, OP_LW, 32'h3000, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_0200);
        tick();
        rdata  = 32'hCAFE_F00D;
        stall  = ST_MEM;
        ex_bus = mk_ex(44'h0, 8'h00, 32'h3004, 1'b0, 1'b0, 1'b1, 5'd10, 32'h5555_5555);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (rf_bus !== mk_rf(1'b1, 5'd9, 32'hCAFE_F00D)) begin
                errors++;
                $display("FAIL hold_cycle_%0d: got %h expected %h", i, rf_bus,
                         mk_rf(1'b1, 5'd9, 32'hCAFE_F00D));
            end
            tick();
            rdata = 32'h0;
        end
        stall  = '0;
        ex_bus = '0;
        #1;
        checks++;
        if (wb_bus !== mk_wb(44'h0, 32'h3000, 1'b1, 5'd9, 32'hCAFE_F00D)) begin
            errors++;
            $display("FAIL hold_release: got %h expected %h", wb_bus,
                     mk_wb(44'h0, 32'h3000, 1'b1, 5'd9, 32'hCAFE_F00D));
        end
        tick();
        checks++;
        if (wb_bus !== '0) begin
            errors++;
            $display("FAIL hold_after: got %h expected 0", wb_bus);
        end
    endtask

    task automatic test_stall_bubble();
        // EX held, MEM free: a bubble enters.
        ex_bus = mk_ex(44'h0, 8'h00, 32'h4000, 1'b0, 1'b0, 1'b1, 5'd4, 32'h1111);
        stall  = 6'b001000;
        tick();
        checks++;
        if (wb_bus !== '0) begin
            errors++;
            $display("FAIL stall_bubble: got %h expected 0", wb_bus);
        end
        // Both held: register keeps its instruction while the EX bus changes.
        stall = '0;
        tick();
        stall  = ST_MEM;
        ex_bus = mk_ex(44'h0, 8'h00, 32'h4008, 1'b0, 1'b0, 1'b1, 5'd8, 32'h2222);
        tick();
        checks++;
        if (wb_bus !== mk_wb(44'h0, 32'h4000, 1'b1, 5'd4, 32'h1111)) begin
            errors++;
            $display("FAIL stall_hold: got %h expected %h", wb_bus,
                     mk_wb(44'h0, 32'h4000, 1'b1, 5'd4, 32'h1111));
        end
        stall  = '0;
        ex_bus = '0;
        tick();
    endtask

    task automatic test_flush();
        ex_bus = mk_ex(44'h0, OP_LW, 32'h5000, 1'b1, 1'b1, 1'b1, 5'd11, 32'h0000_0300);
        tick();
        rdata  = 32'h7777_7777;
        flush  = 1'b1;
        stall  = ST_MEM;
        ex_bus = mk_ex(44'h0, 8'h00, 32'h5004, 1'b0, 1'b0, 1'b1, 5'd12, 32'h9999);
        tick();
        flush  = 1'b0;
        stall  = '0;
        ex_bus = '0;
        #1;
        checks++;
        if (wb_bus !== '0 || rf_bus !== '0) begin
            errors++;
            $display("FAIL flush: wb=%h rf=%h expected all zero", wb_bus, rf_bus);
        end
        tick();
    endtask

    task automatic test_except();
        logic [43:0] exc = 44'hABC_0000_000C;
        ex_bus = mk_ex(exc, 8'h00, 32'h6000, 1'b0, 1'b0, 1'b1, 5'd13, 32'h0000_4444);
        tick();
        ex_bus = '0;
        #1;
        checks++;
        if (wb_bus !== mk_wb(exc, 32'h6000, 1'b0, 5'd13, 32'h0000_4444)) begin
            errors++;
            $display("FAIL except_wb: got %h expected %h", wb_bus,
                     mk_wb(exc, 32'h6000, 1'b0, 5'd13, 32'h0000_4444));
        end
        checks++;
        if (rf_bus !== mk_rf(1'b0, 5'd13, 32'h0000_4444)) begin
            errors++;
            $display("FAIL except_rf: got %h expected %h", rf_bus,
                     mk_rf(1'b0, 5'd13, 32'h0000_4444));
        end
        tick();
    endtask

    task automatic test_async_reset();
        ex_bus = mk_ex(44'h0, OP_LW, 32'h7000, 1'b1, 1'b1, 1'b1, 5'd14, 32'h0000_0400);
        tick();
        rdata  = 32'hBEEF_0001;
        stall  = ST_MEM;
        ex_bus = '0;
        tick();
        rdata = 32'h0;
        #1;
        checks++;
        if (rf_bus !== mk_rf(1'b1, 5'd14, 32'hBEEF_0001)) begin
            errors++;
            $display("FAIL areset_held: got %h expected %h", rf_bus,
                     mk_rf(1'b1, 5'd14, 32'hBEEF_0001));
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (wb_bus !== '0 || rf_bus !== '0) begin
            errors++;
            $display("FAIL areset_async: wb=%h rf=%h expected all zero", wb_bus, rf_bus);
        end
        tick();
        rst    = 1'b0;
        stall  = '0;
        ex_bus = mk_ex(44'h0, OP_LW, 32'h7010, 1'b1, 1'b1, 1'b1, 5'd15, 32'h0000_0404);
        tick();
        rdata  = 32'h0123_4567;
        ex_bus = '0;
        #1;
        checks++;
        if (wb_bus !== mk_wb(44'h0, 32'h7010, 1'b1, 5'd15, 32'h0123_4567)) begin
            errors++;
            $display("FAIL areset_recover: got %h expected %h", wb_bus,
                     mk_wb(44'h0, 32'h7010, 1'b1, 5'd15, 32'h0123_4567));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_align();
        test_alu();
        test_hold();
        test_stall_bubble();
        test_flush();
        test_except();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the EX stage.
- Owns the EX/MEM pipeline register and consumes the EX-to-MEM bus.
- Receives synchronous data-SRAM read data, aligns and extends load data, and produces the MEM-to-WB bus plus the MEM forwarding bus to ID.
- Holds SRAM read data across MEM stalls, because the SRAM output is valid only in the cycle after the request.

Parameters:
- EX_WD, 195, width of ex_to_mem_bus (`EX_INST_INFO).
- WB_WD, 180, width of mem_to_wb_bus.
- FWD_WD, 104, width of mem_to_rf_bus.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  6  pipeline stall vector; stall[3] = EX held, stall[4] = MEM held.
- flush  in  1  exception flush; kills the instruction in the register.
- ex_to_mem_bus  in  EX_WD  fields MSB→LSB:
  - exceptinfo 44 (low 32 bits = excepttype)
  - mem_op 8 {lb,lbu,lh,lhu,lw,sb,sh,sw}
  - hilo_bus 66
  - pc 32
  - ram_en 1, ram_wen 1, ram_sel 4
  - sel_rf_res 1, rf_we 1, rf_waddr 5
  - ex_result 32
- data_sram_rdata  in  32  SRAM read data, valid in the first MEM cycle of a load.
- mem_to_wb_bus  out  WB_WD  {exceptinfo 44, hilo_bus 66, pc 32, rf_we 1, rf_waddr 5, rf_wdata 32}.
- mem_to_rf_bus  out  FWD_WD  {hilo_bus 66, rf_we 1, rf_waddr 5, rf_wdata 32}; forwarding path to ID.

Behaviour:
- Reset: pipeline register, hold buffer and FSM clear asynchronously to all-zero / IDLE. All outputs read 0 while rst is high and in the first cycle after.
- Pipeline register update, evaluated each rising edge in priority order:
  1. flush=1 → load zeros (bubble).
  2. stall[3]=1 and stall[4]=0 → load zeros (bubble).
  3. stall[3]=0 → load ex_to_mem_bus.
  4. Otherwise → hold.
- A zero register is a bubble: rf_we=0, ram_en=0, mem_op=0.
- Read-data hold FSM, tracked only when the registered instruction is a load (mem_op[7:3]≠0) and ram_en=1:
  - IDLE → FRESH when a load enters the register.
  - FRESH: rdata source = data_sram_rdata.
    - If stall[4]=1 → capture data_sram_rdata into hold_buf; go to HELD.
    - Otherwise → the next entry decides IDLE or FRESH.
  - HELD: rdata source = hold_buf; stays HELD while stall[4]=1.
    - On advance → IDLE, or FRESH if another load enters.
  - flush from any state → IDLE; hold_buf is not cleared (don't-care).
  - Back-to-back loads without stall: FRESH → FRESH.
- Load alignment, using ex_result[1:0] of the registered instruction:
  - lb / lbu: byte select 0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24]; sign- or zero-extend to 32 bits.
  - lh / lhu: ex_result[1]=0 → [15:0], else [31:16]; sign- or zero-extend.
  - lw: whole word.
  - Misaligned addresses do not occur here because EX has already flagged them; alignment still uses the low bits, no error.
- rf_wdata: sel_rf_res=1 → aligned load data, else ex_result.
- rf_we_out = rf_we & (excepttype == 0). A faulting instruction never writes the register file, in both output buses.
- exceptinfo, hilo_bus and pc pass through unchanged from the register.
- Latency: one cycle from EX bus to outputs. Both output buses are combinational off the register and the hold path.
- No stall request is generated by this block.

Decomposition:
- defines.vh holds: EX_INST_INFO, MEM_TO_WB_WD, MEM_TO_RF_WD, HILO_WD, EXCEPT_WD, stall bit indices, ZeroWord.
- FSM state encodings are local parameters inside mem_stage.
- One combinational sub-module, load_align, with inputs mem_op[7:3], addr[1:0], rdata[31:0] and output data[31:0].

Test Plan:
- lw, addr 0x100, rdata 0xDEADBEEF, no stall → next cycle rf_wdata=0xDEADBEEF, rf_we=1, rf_waddr matches.
- lb addr[1:0]=2, rdata 0x12F45678 → rf_wdata=0xFFFFFFF4; same with lbu → 0x000000F4; lhu addr[1]=1 → 0x000012F4.
- lw with rdata 0xCAFEF00D and stall[4]=1 for 3 cycles while rdata is driven to 0x0 after the first cycle → rf_wdata stays 0xCAFEF00D throughout and at release.
- stall=6'b001000 → register loads a bubble, rf_we=0; flush=1 with a valid lw in flight → next cycle all-zero, FSM IDLE.
- Instruction with excepttype=0x0C and rf_we=1 → both buses show rf_we=0; exceptinfo passes through intact.
- Assert rst mid-HELD → outputs zero immediately (async); after deassert, a fresh lw completes normally.
